// File: rtl/shift_add_mul8_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// the FSM state encoding and the operand width.
package shift_add_mul8_pkg;

  localparam int MUL_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mul8_adder8.sv
// 8-bit adder/subtractor stage: carry_in doubles as the subtract select
// (b is inverted and the +1 comes in through carry_in).
module adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  output logic [7:0] sum,
  output logic       carry_out
);

  logic [7:0] b_eff;
  logic [8:0] full;

  always_comb begin
    b_eff = carry_in ? ~b : b;
    full  = {1'b0, a} + {1'b0, b_eff} + {8'b0, carry_in};
  end

  assign sum       = full[7:0];
  assign carry_out = full[8];

endmodule

// File: rtl/shift_add_mul8.sv
// Sequential unsigned 8x8 -> 16 multiplier: one multiplier bit per cycle,
// accumulating through a single adder8, with valid/ready on both sides.
module shift_add_mul8
  import shift_add_mul8_pkg::*;
#(
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MUL_BITS-1:0]   a,
  input  logic [MUL_BITS-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*MUL_BITS-1:0] product,
  output logic                  busy
);

  state_t              state;
  logic [MUL_BITS-1:0] acc;
  logic [MUL_BITS-1:0] mq;
  logic [MUL_BITS-1:0] mcand;
  logic [2:0]          count;

  logic [MUL_BITS-1:0] add_b;
  logic [MUL_BITS-1:0] sum;
  logic                carry_out;
  logic [MUL_BITS-1:0] acc_next;
  logic [MUL_BITS-1:0] mq_next;

  assign add_b = mq[0] ? mcand : '0;

  // carry_in is the subtract select of adder8; this datapath only ever adds.
  adder8 u_adder8 (
    .a         (acc),
    .b         (add_b),
    .carry_in  (1'b0),
    .sum       (sum),
    .carry_out (carry_out)
  );

  // The adder's carry becomes the new acc MSB; acc LSB shifts into mq.
  assign {acc_next, mq_next} = {carry_out, sum, mq[MUL_BITS-1:1]};

  // NOTE: all state and outputs update with non-blocking assignments so every
  // register sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      acc       <= '0;
      mq        <= '0;
      mcand     <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= a;
            mq       <= b;
            acc      <= '0;
            count    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (ZERO_BYPASS && (a == '0 || b == '0)) begin
              product   <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          acc   <= acc_next;
          mq    <= mq_next;
          count <= count + 3'd1;
          if (count == 3'(MUL_BITS - 1)) begin
            product   <= {acc_next, mq_next};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          // Product and out_valid hold here until the consumer takes them.
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
